// File: rtl/vga_sync_rx.sv
// Sink-side VGA timing recovery: measures line/frame length, locks, regenerates pixel_x/pixel_y.
// Optional nominal-format check enabled by defining SYNC_RX_NOMINAL_CHECK_EN.
module vga_sync_rx #(
  parameter int LOCK_FRAMES = 2,
  parameter int HD          = 640,
  parameter int HTOT        = 800,
  parameter int VD          = 480,
  parameter int VTOT        = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        de_out,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic        lock_lost,
  output logic        fmt_err
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

`ifdef SYNC_RX_NOMINAL_CHECK_EN
  localparam bit NomChk = 1'b1;
`else
  localparam bit NomChk = 1'b0;
`endif

  // A nonsensical parameter set never locks
  localparam bit CfgOk = (LOCK_FRAMES >= 1) && (LOCK_FRAMES <= 7) &&
                         (HD < HTOT) && (VD < VTOT) &&
                         (HTOT < 2048) && (VTOT < 2048);

  localparam logic [10:0] CntMax = 11'h7FF;
  localparam logic [10:0] HtotW  = 11'(HTOT);
  localparam logic [10:0] VtotW  = 11'(VTOT);
  localparam logic [2:0]  LfW    = 3'(LOCK_FRAMES);

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CntMax) ? v : v + 11'd1;
  endfunction

  logic hs_s_q, hs_p_q;
  logic vs_s_q, vs_p_q;
  logic de_s_q, de_p_q;
  logic hs_rise, vs_rise, de_rise, de_fall;

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d, vcnt_inc;
  logic [10:0] h_meas_q, h_meas_d;
  logic [10:0] v_meas_q, v_meas_d;
  logic        timeout;

  state_e      state_q, state_d;
  logic [2:0]  stb_q, stb_d;
  logic [10:0] h_total_q, h_total_d;
  logic [10:0] v_total_q, v_total_d;
  logic        meas_match;

  logic        locked_q, locked_d;
  logic        lock_lost_q, lock_lost_d;
  logic        de_out_q, de_out_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_s_q <= 1'b0;
      hs_p_q <= 1'b0;
      vs_s_q <= 1'b0;
      vs_p_q <= 1'b0;
      de_s_q <= 1'b0;
      de_p_q <= 1'b0;
    end else if (pix_en) begin
      hs_s_q <= hsync_in;
      hs_p_q <= hs_s_q;
      vs_s_q <= vsync_in;
      vs_p_q <= vs_s_q;
      de_s_q <= de_in;
      de_p_q <= de_s_q;
    end
  end

  assign hs_rise = hs_s_q & ~hs_p_q;
  assign vs_rise = vs_s_q & ~vs_p_q;
  assign de_rise = de_s_q & ~de_p_q;
  assign de_fall = ~de_s_q & de_p_q;

  // A coincident hs rise is counted into the frame it closes
  always_comb begin
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    vcnt_inc = vcnt_q;
    h_meas_d = h_meas_q;
    v_meas_d = v_meas_q;
    if (pix_en) begin
      if (hs_rise) begin
        vcnt_inc = sat_inc(vcnt_q);
        h_meas_d = sat_inc(hcnt_q);
        hcnt_d   = '0;
      end else begin
        hcnt_d   = sat_inc(hcnt_q);
      end
      if (vs_rise) begin
        v_meas_d = vcnt_inc;
        vcnt_d   = '0;
      end else begin
        vcnt_d   = vcnt_inc;
      end
    end
  end

  assign timeout = pix_en &
                   ((hcnt_d == CntMax) | (vcnt_d == CntMax));

  assign meas_match = (h_meas_d == h_total_q) &&
                      (v_meas_d == v_total_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      stb_q     <= '0;
      h_total_q <= '0;
      v_total_q <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      h_meas_q  <= '0;
      v_meas_q  <= '0;
    end else begin
      state_q   <= state_d;
      stb_q     <= stb_d;
      h_total_q <= h_total_d;
      v_total_q <= v_total_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      h_meas_q  <= h_meas_d;
      v_meas_q  <= v_meas_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stb_d     = stb_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    if (pix_en) begin
      if (timeout) begin
        state_d = SEARCH;
        stb_d   = '0;
      end else begin
        unique case (state_q)
          SEARCH: begin
            if (vs_rise) begin
              state_d = MEASURE;
              stb_d   = '0;
            end
          end
          MEASURE: begin
            if (vs_rise) begin
              if ((stb_q != 3'd0) && meas_match) begin
                stb_d = (stb_q == 3'd7) ? stb_q : stb_q + 3'd1;
              end else begin
                h_total_d = h_meas_d;
                v_total_d = v_meas_d;
                stb_d     = 3'd1;
              end
              if (CfgOk && (stb_d >= LfW) &&
                  (!NomChk || ((h_total_d == HtotW) &&
                               (v_total_d == VtotW)))) begin
                state_d = LOCKED;
              end
            end
          end
          LOCKED: begin
            if ((hs_rise && (h_meas_d != h_total_q)) ||
                (vs_rise && (v_meas_d != v_total_q))) begin
              state_d = SEARCH;
              stb_d   = '0;
            end
          end
          default: begin
            state_d = SEARCH;
            stb_d   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    locked_d    = (state_d == LOCKED);
    lock_lost_d = pix_en & (state_q == LOCKED) &
                  (state_d != LOCKED);
  end

  // de_out follows the lock decision made on the same edge
  always_comb begin
    px_d     = px_q;
    py_d     = py_q;
    de_out_d = de_out_q;
    if (pix_en) begin
      de_out_d = locked_d & de_s_q;
      if (de_rise) begin
        px_d = '0;
      end else if (de_s_q) begin
        px_d = px_q + 10'd1;
      end
      if (vs_rise) begin
        py_d = '0;
      end else if (de_fall) begin
        py_d = py_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      de_out_q    <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
    end else begin
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      de_out_q    <= de_out_d;
      px_q        <= px_d;
      py_q        <= py_d;
    end
  end

`ifdef SYNC_RX_NOMINAL_CHECK_EN
  logic fmt_err_q, fmt_err_d;

  always_comb begin
    fmt_err_d = (state_d == MEASURE) && (stb_d != 3'd0) &&
                ((h_total_d != HtotW) || (v_total_d != VtotW));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fmt_err_q <= 1'b0;
    end else begin
      fmt_err_q <= fmt_err_d;
    end
  end

  assign fmt_err = fmt_err_q;
`else
  assign fmt_err = 1'b0;
`endif

  assign pixel_x   = px_q;
  assign pixel_y   = py_q;
  assign de_out    = de_out_q;
  assign locked    = locked_q;
  assign h_total   = h_total_q;
  assign v_total   = v_total_q;
  assign lock_lost = lock_lost_q;

endmodule
